lane_stage3_wb: RTL and testbench
=================================

Name: lane_stage3_wb

Overview:
- Parametrised next-generation lane stage-3 write-back buffer.
- Accepts execute results, translates groupCounter into a VRF (vd, offset) address, and buffers requests in a DEPTH-entry in-order queue toward the VRF write port.
- Adds over the previous generation:
  - configurable widths and depth;
  - a real `last` flag;
  - zero-mask write suppression;
  - occupancy reporting;
  - optional tail write merging.

Parameters:
- DATA_WIDTH, 32, write data width in bits; must be a multiple of 8. MASK_WIDTH = DATA_WIDTH/8.
- DEPTH, 4, queue entries, ≥2.
- GROUP_WIDTH, 10, groupCounter width.
- OFFSET_WIDTH, 6, low groupCounter bits forming the VRF offset; must be < GROUP_WIDTH.
- VD_WIDTH, 5, vector register index width.
- INST_WIDTH, 3, instructionIndex width.
- AF_LEVEL, 1, almostFull asserts when free entries ≤ AF_LEVEL.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- enqueue_valid  in  1  producer valid
- enqueue_ready  out  1  stage can accept
- enqueue_bits_groupCounter  in  GROUP_WIDTH  element group index
- enqueue_bits_vd  in  VD_WIDTH  base destination register
- enqueue_bits_data  in  DATA_WIDTH  result data
- enqueue_bits_mask  in  MASK_WIDTH  byte enables
- enqueue_bits_last  in  1  final write of instruction
- enqueue_bits_instructionIndex  in  INST_WIDTH  instruction tag
- vrfWriteRequest_valid  out  1  head entry valid
- vrfWriteRequest_ready  in  1  VRF accepts
- vrfWriteRequest_bits_vd  out  VD_WIDTH
- vrfWriteRequest_bits_offset  out  OFFSET_WIDTH
- vrfWriteRequest_bits_mask  out  MASK_WIDTH
- vrfWriteRequest_bits_data  out  DATA_WIDTH
- vrfWriteRequest_bits_last  out  1
- vrfWriteRequest_bits_instructionIndex  out  INST_WIDTH
- occupancy  out  $clog2(DEPTH+1)  valid entries
- almostFull  out  1  free entries ≤ AF_LEVEL

Behaviour:
- Interface: single clock `clock`; reset `reset` is asynchronous and active-high.
- Reset values, applied immediately on assertion, including mid-operation:
  - pointers and occupancy = 0;
  - vrfWriteRequest_valid = 0;
  - enqueue_ready = 1;
  - almostFull = (DEPTH ≤ AF_LEVEL);
  - entry contents are don't-care;
  - all request bits are don't-care while valid = 0.
- Address translation: vd = enqueue_bits_vd + groupCounter[GROUP_WIDTH-1:OFFSET_WIDTH], truncated to VD_WIDTH (wraps modulo 2^VD_WIDTH). offset = groupCounter[OFFSET_WIDTH-1:0].
- Ready: enqueue_ready = (occupancy != DEPTH). It is registered state only, with no combinational path from vrfWriteRequest_ready or enqueue inputs.
- Handshake fires:
  - enq fire = enqueue_valid & enqueue_ready;
  - deq fire = vrfWriteRequest_valid & vrfWriteRequest_ready.
- Outputs: vrfWriteRequest_valid = (occupancy != 0); bits are the head entry, read combinationally from storage.
- Latency: an entry pushed into an empty queue appears at the output in the next cycle. There is no same-cycle bypass.
- Zero mask: an enq fire with mask == 0 and last == 0 is accepted and discarded (no push). If mask == 0 and last == 1, the entry is pushed so `last` reaches the VRF.
- Push + pop in the same cycle: occupancy is unchanged and both pointers advance.
- Pointers wrap from DEPTH-1 to 0 (DEPTH need not be a power of two).
- Order is strictly FIFO; data and address are never reordered.

Optional Feature:
- Macro: LANE_STAGE3_WB_MERGE_EN.
- With the macro defined: on an enq fire, the write merges into the tail entry instead of pushing when all of the following hold:
  - occupancy ≥ 1;
  - tail vd, offset and instructionIndex equal the incoming values;
  - tail last == 0;
  - NOT (occupancy == 1 and deq fire this cycle).
- Merge effect:
  - tail data bytes with incoming mask = 1 are replaced;
  - tail mask |= incoming mask;
  - tail last = incoming last;
  - occupancy and pointers are unchanged (a simultaneous deq fire still pops).
- Zero-mask suppression takes priority over merge when last == 0.
- Without the macro: no merging; every non-suppressed fire pushes.

Decomposition:
- Package lane_stage3_wb_pkg:
  - default parameter constants;
  - function byte_merge(old_data, old_mask, new_data, new_mask) returning merged data.
- Entry packing stays local to the module, because entry width depends on module parameters.
- One sub-module, lane_wb_fifo: parametrised register-array FIFO with push, pop, a tail-rewrite port, occupancy and full/empty.

Test Plan:
- Reset (asserted asynchronously mid-burst, occupancy 3) -> valid drops to 0 immediately, ready = 1, occupancy = 0; no stale entry is emitted after release.
- Address: vd = 30, groupCounter = 0x0C5 -> output vd = 1 (30+3 wraps modulo 32), offset = 0x05, one cycle after the fire.
- Fill: vrfWriteRequest_ready = 0, 4 pushes -> ready = 0 after the 4th, occupancy = 4, almostFull = 1 from occupancy 3. Release ready -> 4 pops in order, and enqueue_ready returns the cycle after the first pop.
- Simultaneous push+pop at occupancy 2 -> occupancy stays 2 and ordering is preserved.
- Mask = 0, last = 0 -> accepted, occupancy unchanged. Mask = 0, last = 1 -> one entry with last = 1 is emitted.
- With MERGE_EN: two writes to the same (vd 2, offset 7, inst 1), data 0x11111111 mask 0x3 then 0x22222222 mask 0xC, ready held low -> a single entry with data 0x22221111, mask 0xF. Without the macro -> two entries.

Source files
------------

// File: rtl/lane_stage3_wb_pkg.sv
// lane_stage3_wb_pkg: shared defaults and the byte-lane merge helper for the stage-3 write-back buffer.
// Rev 1.0
`default_nettype none

package lane_stage3_wb_pkg;

  localparam int c_DATA_WIDTH     = 32;
  localparam int c_DEPTH          = 4;
  localparam int c_GROUP_WIDTH    = 10;
  localparam int c_OFFSET_WIDTH   = 6;
  localparam int c_VD_WIDTH       = 5;
  localparam int c_INST_WIDTH     = 3;
  localparam int c_AF_LEVEL       = 1;

  // Widest data path the merge helper supports; callers zero-extend into it.
  localparam int c_MAX_DATA_WIDTH = 1024;
  localparam int c_MAX_MASK_WIDTH = c_MAX_DATA_WIDTH / 8;

  // Bytes enabled by neither mask carry no meaning and are cleared.
  function automatic logic [c_MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [c_MAX_DATA_WIDTH-1:0] old_data,
    input logic [c_MAX_MASK_WIDTH-1:0] old_mask,
    input logic [c_MAX_DATA_WIDTH-1:0] new_data,
    input logic [c_MAX_MASK_WIDTH-1:0] new_mask
  );
    logic [c_MAX_DATA_WIDTH-1:0] w_result;
    w_result = '0;
    for (int i = 0; i < c_MAX_MASK_WIDTH; i++) begin
      if (new_mask[i]) begin
        w_result[i*8 +: 8] = new_data[i*8 +: 8];
      end else if (old_mask[i]) begin
        w_result[i*8 +: 8] = old_data[i*8 +: 8];
      end
    end
    return w_result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_wb_fifo.sv
// lane_wb_fifo: register-array in-order queue with push, pop, tail rewrite and registered full/empty.
// Rev 1.0
`default_nettype none

module lane_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_rewrite,
  input  logic [WIDTH-1:0]           i_rewrite_data,
  output logic [WIDTH-1:0]           o_head_data,
  output logic [WIDTH-1:0]           o_tail_data,
  output logic [$clog2(DEPTH+1)-1:0] o_occupancy,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH-1);
  localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_full;
  logic               r_empty;
  logic [c_CNT_W-1:0] w_count_next;
  logic [c_PTR_W-1:0] w_tail_ptr;

  // Most recently written slot; pointers wrap explicitly so DEPTH need not be a power of two.
  assign w_tail_ptr = (r_wr_ptr == '0) ? c_LAST_PTR : r_wr_ptr - 1'b1;

  always_comb begin
    w_count_next = r_count;
    if (i_push && !i_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!i_push && i_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) begin
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  // Storage has no reset; contents are only observed behind a valid count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end else if (i_rewrite) begin
      r_mem[w_tail_ptr] <= i_rewrite_data;
    end
  end

  assign o_head_data = r_mem[r_rd_ptr];
  assign o_tail_data = r_mem[w_tail_ptr];
  assign o_occupancy = r_count;
  assign o_full      = r_full;
  assign o_empty     = r_empty;

endmodule

`default_nettype wire

// File: rtl/lane_stage3_wb.sv
// lane_stage3_wb: stage-3 write-back buffer, groupCounter -> (vd, offset), in-order queue to the VRF.
// Rev 1.0 -- define LANE_STAGE3_WB_MERGE_EN to merge matching writes into the tail entry.
`default_nettype none

module lane_stage3_wb
  import lane_stage3_wb_pkg::*;
#(
  parameter int DATA_WIDTH   = c_DATA_WIDTH,
  parameter int DEPTH        = c_DEPTH,
  parameter int GROUP_WIDTH  = c_GROUP_WIDTH,
  parameter int OFFSET_WIDTH = c_OFFSET_WIDTH,
  parameter int VD_WIDTH     = c_VD_WIDTH,
  parameter int INST_WIDTH   = c_INST_WIDTH,
  parameter int AF_LEVEL     = c_AF_LEVEL
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enqueue_valid,
  output logic                         enqueue_ready,
  input  logic [GROUP_WIDTH-1:0]       enqueue_bits_groupCounter,
  input  logic [VD_WIDTH-1:0]          enqueue_bits_vd,
  input  logic [DATA_WIDTH-1:0]        enqueue_bits_data,
  input  logic [DATA_WIDTH/8-1:0]      enqueue_bits_mask,
  input  logic                         enqueue_bits_last,
  input  logic [INST_WIDTH-1:0]        enqueue_bits_instructionIndex,
  output logic                         vrfWriteRequest_valid,
  input  logic                         vrfWriteRequest_ready,
  output logic [VD_WIDTH-1:0]          vrfWriteRequest_bits_vd,
  output logic [OFFSET_WIDTH-1:0]      vrfWriteRequest_bits_offset,
  output logic [DATA_WIDTH/8-1:0]      vrfWriteRequest_bits_mask,
  output logic [DATA_WIDTH-1:0]        vrfWriteRequest_bits_data,
  output logic                         vrfWriteRequest_bits_last,
  output logic [INST_WIDTH-1:0]        vrfWriteRequest_bits_instructionIndex,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         almostFull
);

  localparam int c_MASK_W = DATA_WIDTH / 8;
  localparam int c_CNT_W  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [VD_WIDTH-1:0]     vd;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [INST_WIDTH-1:0]   inst;
    logic                    last;
    logic [c_MASK_W-1:0]     mask;
    logic [DATA_WIDTH-1:0]   data;
  } entry_t;

  entry_t             w_enq_entry;
  entry_t             w_head_entry;
  entry_t             w_tail_entry;
  entry_t             w_rewrite_entry;
  logic [c_CNT_W-1:0] w_occupancy;
  logic               w_full;
  logic               w_empty;
  logic               w_enq_fire;
  logic               w_deq_fire;
  logic               w_suppress;
  logic               w_merge;
  logic               w_push;

  // Upper groupCounter bits step the register index; the sum wraps modulo 2^VD_WIDTH.
  assign w_enq_entry.vd     = enqueue_bits_vd
                            + VD_WIDTH'(enqueue_bits_groupCounter[GROUP_WIDTH-1:OFFSET_WIDTH]);
  assign w_enq_entry.offset = enqueue_bits_groupCounter[OFFSET_WIDTH-1:0];
  assign w_enq_entry.inst   = enqueue_bits_instructionIndex;
  assign w_enq_entry.last   = enqueue_bits_last;
  assign w_enq_entry.mask   = enqueue_bits_mask;
  assign w_enq_entry.data   = enqueue_bits_data;

  assign enqueue_ready         = !w_full;
  assign vrfWriteRequest_valid = !w_empty;
  assign w_enq_fire            = enqueue_valid && enqueue_ready;
  assign w_deq_fire            = vrfWriteRequest_valid && vrfWriteRequest_ready;

  // A write with no enabled bytes is dropped unless it carries the instruction's last marker.
  assign w_suppress = (enqueue_bits_mask == '0) && !enqueue_bits_last;

`ifdef LANE_STAGE3_WB_MERGE_EN
  logic                        w_tail_match;
  logic [c_MAX_DATA_WIDTH-1:0] w_old_data_ext;
  logic [c_MAX_MASK_WIDTH-1:0] w_old_mask_ext;
  logic [c_MAX_DATA_WIDTH-1:0] w_new_data_ext;
  logic [c_MAX_MASK_WIDTH-1:0] w_new_mask_ext;

  assign w_tail_match = (w_tail_entry.vd == w_enq_entry.vd)
                     && (w_tail_entry.offset == w_enq_entry.offset)
                     && (w_tail_entry.inst == w_enq_entry.inst);

  // A lone entry leaving this cycle cannot be merged into, so it becomes a fresh push.
  assign w_merge = w_enq_fire && !w_suppress && !w_empty && w_tail_match
                && !w_tail_entry.last
                && !((w_occupancy == c_CNT_W'(1)) && w_deq_fire);

  always_comb begin
    w_old_data_ext                   = '0;
    w_old_mask_ext                   = '0;
    w_new_data_ext                   = '0;
    w_new_mask_ext                   = '0;
    w_old_data_ext[DATA_WIDTH-1:0]   = w_tail_entry.data;
    w_old_mask_ext[c_MASK_W-1:0]     = w_tail_entry.mask;
    w_new_data_ext[DATA_WIDTH-1:0]   = enqueue_bits_data;
    w_new_mask_ext[c_MASK_W-1:0]     = enqueue_bits_mask;
    w_rewrite_entry                  = w_tail_entry;
    w_rewrite_entry.mask             = w_tail_entry.mask | enqueue_bits_mask;
    w_rewrite_entry.last             = enqueue_bits_last;
    w_rewrite_entry.data             = DATA_WIDTH'(byte_merge(w_old_data_ext, w_old_mask_ext,
                                                              w_new_data_ext, w_new_mask_ext));
  end
`else
  assign w_merge         = 1'b0;
  assign w_rewrite_entry = w_tail_entry;
`endif

  assign w_push = w_enq_fire && !w_suppress && !w_merge;

  lane_wb_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk            (clock),
    .rst            (reset),
    .i_push         (w_push),
    .i_pop          (w_deq_fire),
    .i_push_data    (w_enq_entry),
    .i_rewrite      (w_merge),
    .i_rewrite_data (w_rewrite_entry),
    .o_head_data    (w_head_entry),
    .o_tail_data    (w_tail_entry),
    .o_occupancy    (w_occupancy),
    .o_full         (w_full),
    .o_empty        (w_empty)
  );

  assign vrfWriteRequest_bits_vd               = w_head_entry.vd;
  assign vrfWriteRequest_bits_offset           = w_head_entry.offset;
  assign vrfWriteRequest_bits_mask             = w_head_entry.mask;
  assign vrfWriteRequest_bits_data             = w_head_entry.data;
  assign vrfWriteRequest_bits_last             = w_head_entry.last;
  assign vrfWriteRequest_bits_instructionIndex = w_head_entry.inst;

  assign occupancy  = w_occupancy;
  assign almostFull = (32'(DEPTH) - 32'(w_occupancy)) <= 32'(AF_LEVEL);

endmodule

`default_nettype wire

// File: tb/tb_lane_stage3_wb.sv
// tb_lane_stage3_wb: directed vector table plus hand sequences for the stage-3 write-back buffer.
// Rev 1.0
`default_nettype none

module tb_lane_stage3_wb;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid;
  logic        enq_ready;
  logic [9:0]  enq_gc;
  logic [4:0]  enq_vd;
  logic [31:0] enq_data;
  logic [3:0]  enq_mask;
  logic        enq_last;
  logic [2:0]  enq_inst;
  logic        vrf_valid;
  logic        vrf_ready;
  logic [4:0]  vrf_vd;
  logic [5:0]  vrf_off;
  logic [3:0]  vrf_mask;
  logic [31:0] vrf_data;
  logic        vrf_last;
  logic [2:0]  vrf_inst;
  logic [2:0]  occ;
  logic        afull;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lane_stage3_wb dut (
    .clock                                (clk),
    .reset                                (rst),
    .enqueue_valid                        (enq_valid),
    .enqueue_ready                        (enq_ready),
    .enqueue_bits_groupCounter            (enq_gc),
    .enqueue_bits_vd                      (enq_vd),
    .enqueue_bits_data                    (enq_data),
    .enqueue_bits_mask                    (enq_mask),
    .enqueue_bits_last                    (enq_last),
    .enqueue_bits_instructionIndex        (enq_inst),
    .vrfWriteRequest_valid                (vrf_valid),
    .vrfWriteRequest_ready                (vrf_ready),
    .vrfWriteRequest_bits_vd              (vrf_vd),
    .vrfWriteRequest_bits_offset          (vrf_off),
    .vrfWriteRequest_bits_mask            (vrf_mask),
    .vrfWriteRequest_bits_data            (vrf_data),
    .vrfWriteRequest_bits_last            (vrf_last),
    .vrfWriteRequest_bits_instructionIndex(vrf_inst),
    .occupancy                            (occ),
    .almostFull                           (afull)
  );

  typedef struct {
    logic [4:0]  vd;
    logic [9:0]  gc;
    logic [31:0] data;
    logic [3:0]  mask;
    logic        last;
    logic [2:0]  inst;
    logic [4:0]  exp_vd;
    logic [5:0]  exp_off;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] vd, input logic [9:0] gc, input logic [31:0] d,
                       input logic [3:0] m, input logic l, input logic [2:0] inst);
    enq_valid = 1'b1;
    enq_vd    = vd;
    enq_gc    = gc;
    enq_data  = d;
    enq_mask  = m;
    enq_last  = l;
    enq_inst  = inst;
  endtask

  task automatic push(input logic [4:0] vd, input logic [9:0] gc, input logic [31:0] d,
                      input logic [3:0] m, input logic l, input logic [2:0] inst);
    drive(vd, gc, d, m, l, inst);
    step();
    enq_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{vd: 5'd30, gc: 10'h0C5, data: 32'hDEADBEEF, mask: 4'hF, last: 1'b0, inst: 3'd2, exp_vd: 5'd1,  exp_off: 6'h05};
    vecs[1] = '{vd: 5'd0,  gc: 10'h000, data: 32'h01234567, mask: 4'h1, last: 1'b1, inst: 3'd0, exp_vd: 5'd0,  exp_off: 6'h00};
    vecs[2] = '{vd: 5'd5,  gc: 10'h3FF, data: 32'hA5A5A5A5, mask: 4'h8, last: 1'b0, inst: 3'd7, exp_vd: 5'd20, exp_off: 6'h3F};
    vecs[3] = '{vd: 5'd31, gc: 10'h040, data: 32'h12345678, mask: 4'h6, last: 1'b1, inst: 3'd3, exp_vd: 5'd0,  exp_off: 6'h00};
    vecs[4] = '{vd: 5'd7,  gc: 10'h000, data: 32'hCAFEF00D, mask: 4'h0, last: 1'b1, inst: 3'd4, exp_vd: 5'd7,  exp_off: 6'h00};
    vecs[5] = '{vd: 5'd16, gc: 10'h2A1, data: 32'h00000000, mask: 4'h5, last: 1'b0, inst: 3'd5, exp_vd: 5'd26, exp_off: 6'h21};

    rst       = 1'b1;
    enq_valid = 1'b0;
    enq_vd    = '0;
    enq_gc    = '0;
    enq_data  = '0;
    enq_mask  = '0;
    enq_last  = 1'b0;
    enq_inst  = '0;
    vrf_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 64'(vrf_valid), 64'd0);
    chk("reset_ready", 64'(enq_ready), 64'd1);
    chk("reset_occ",   64'(occ),       64'd0);
    chk("reset_afull", 64'(afull),     64'd0);
    rst = 1'b0;
    step();

    // Vector table: single-entry round trip, output one cycle after the fire.
    for (int i = 0; i < 6; i++) begin
      push(vecs[i].vd, vecs[i].gc, vecs[i].data, vecs[i].mask, vecs[i].last, vecs[i].inst);
      chk($sformatf("vec%0d_valid", i), 64'(vrf_valid), 64'd1);
      chk($sformatf("vec%0d_bits", i),
          64'({vrf_vd, vrf_off, vrf_inst, vrf_last, vrf_mask, vrf_data}),
          64'({vecs[i].exp_vd, vecs[i].exp_off, vecs[i].inst, vecs[i].last, vecs[i].mask, vecs[i].data}));
      vrf_ready = 1'b1;
      step();
      vrf_ready = 1'b0;
      chk($sformatf("vec%0d_drain", i), 64'(vrf_valid), 64'd0);
    end

    // Fill to DEPTH with the VRF stalled, then drain in order.
    for (int i = 0; i < 4; i++) begin
      push(5'd1, 10'(i), 32'hA0000000 + 32'(i), 4'hF, 1'b0, 3'd1);
      chk($sformatf("fill%0d_occ", i),   64'(occ),       64'(i + 1));
      chk($sformatf("fill%0d_afull", i), 64'(afull),     64'((i + 1) >= 3));
      chk($sformatf("fill%0d_ready", i), 64'(enq_ready), 64'((i + 1) != 4));
    end
    chk("fill_head", 64'(vrf_data), 64'h00000000A0000000);
    vrf_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      if (i == 1) chk("fill_ready_after_pop", 64'(enq_ready), 64'd1);
      chk($sformatf("drain%0d_data", i), 64'(vrf_data), 64'(32'hA0000000 + 32'(i)));
    end
    step();
    chk("drain_empty", 64'(vrf_valid), 64'd0);
    vrf_ready = 1'b0;

    // Push and pop together at occupancy 2.
    push(5'd3, 10'd0, 32'hB0, 4'hF, 1'b0, 3'd2);
    push(5'd3, 10'd1, 32'hB1, 4'hF, 1'b0, 3'd2);
    chk("pp_occ_before", 64'(occ), 64'd2);
    drive(5'd3, 10'd2, 32'hB2, 4'hF, 1'b0, 3'd2);
    vrf_ready = 1'b1;
    step();
    enq_valid = 1'b0;
    chk("pp_occ_after", 64'(occ), 64'd2);
    chk("pp_head1", 64'(vrf_data), 64'hB1);
    step();
    chk("pp_head2", 64'(vrf_data), 64'hB2);
    step();
    chk("pp_empty", 64'(occ), 64'd0);
    vrf_ready = 1'b0;

    // Zero mask without last is accepted and dropped.
    chk("zm_ready", 64'(enq_ready), 64'd1);
    push(5'd4, 10'd0, 32'hFFFFFFFF, 4'h0, 1'b0, 3'd0);
    chk("zm_occ", 64'(occ), 64'd0);
    chk("zm_valid", 64'(vrf_valid), 64'd0);

    // Two writes to the same (vd 2, offset 7, inst 1).
    push(5'd2, 10'd7, 32'h11111111, 4'h3, 1'b0, 3'd1);
    push(5'd2, 10'd7, 32'h22222222, 4'hC, 1'b0, 3'd1);
`ifdef LANE_STAGE3_WB_MERGE_EN
    chk("merge_occ",  64'(occ),      64'd1);
    chk("merge_data", 64'(vrf_data), 64'h22221111);
    chk("merge_mask", 64'(vrf_mask), 64'hF);
`else
    chk("merge_occ",  64'(occ),      64'd2);
    chk("merge_data", 64'(vrf_data), 64'h11111111);
    chk("merge_mask", 64'(vrf_mask), 64'h3);
`endif
    vrf_ready = 1'b1;
    repeat (2) step();
    chk("merge_drain", 64'(vrf_valid), 64'd0);
    vrf_ready = 1'b0;

    // Asynchronous reset mid-burst at occupancy 3.
    drive(5'd6, 10'd0, 32'hC0, 4'hF, 1'b0, 3'd6);
    step();
    drive(5'd6, 10'd1, 32'hC1, 4'hF, 1'b0, 3'd6);
    step();
    drive(5'd6, 10'd2, 32'hC2, 4'hF, 1'b0, 3'd6);
    step();
    drive(5'd6, 10'd3, 32'hC3, 4'hF, 1'b0, 3'd6);
    chk("ar_occ_before", 64'(occ), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(vrf_valid), 64'd0);
    chk("ar_ready", 64'(enq_ready), 64'd1);
    chk("ar_occ",   64'(occ),       64'd0);
    enq_valid = 1'b0;
    repeat (2) step();
    rst       = 1'b0;
    vrf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ar_post%0d_valid", i), 64'(vrf_valid), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
